// File: rtl/rom_arb_pkg.sv
// Shared constants and FSM encoding for the ROM read arbiter.
package rom_arb_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W      = 2;

  typedef logic [0:0] state_t;
  localparam state_t ST_ARB   = 1'b0;
  localparam state_t ST_ISSUE = 1'b1;
endpackage

// File: rtl/rom_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after `last` wins.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             vld,
  output logic [ID_W-1:0]  win
);
  int idx;

  // Scan from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    vld = 1'b0;
    win = '0;
    idx = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (req[idx]) begin
        vld = 1'b1;
        win = idx[ID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous 1024x8 ROM between N_REQ clients.
// Optional ROM_ARB_BURST_EN: grants carry 1..4 beats from req_len.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req,
  input  logic [N_REQ-1:0][ADDR_W-1:0]      req_addr,
  input  logic [N_REQ-1:0][LEN_W-1:0]       req_len,
  output logic [N_REQ-1:0]                  gnt,
  output logic [ADDR_W-1:0]                 rom_address,
  output logic                              rom_enable,
  input  logic [DATA_W-1:0]                 rom_data,
  output logic [DATA_W-1:0]                 rd_data,
  output logic [N_REQ-1:0]                  rd_valid,
  output logic                              busy
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t          state;
  logic [ID_W-1:0] last_id, cur_id, pick_id, id_s1;
  logic            pick_vld, issuing, last_beat;
  logic [2:1]      vld_pipe;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req  (req),
    .last (last_id),
    .vld  (pick_vld),
    .win  (pick_id)
  );

  assign issuing = (state == ST_ISSUE);
  assign busy    = issuing | (|vld_pipe);

`ifdef ROM_ARB_BURST_EN
  logic [LEN_W-1:0] beats;
  assign last_beat = (beats == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          beats <= '0;
    else if (!issuing && pick_vld)    beats <= req_len[pick_id];
    else if (issuing && !last_beat)   beats <= beats - LEN_W'(1);
  end
`else
  logic unused_len;
  assign unused_len = ^req_len;
  assign last_beat  = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_ARB;
      last_id     <= ID_W'(N_REQ - 1);
      cur_id      <= '0;
      gnt         <= '0;
      rom_address <= '0;
      rom_enable  <= 1'b1;
    end else begin
      case (state)
        ST_ARB: begin
          if (pick_vld) begin
            state       <= ST_ISSUE;
            cur_id      <= pick_id;
            last_id     <= pick_id;
            gnt         <= N_REQ'(1) << pick_id;
            rom_address <= req_addr[pick_id];
            rom_enable  <= 1'b0;
          end else begin
            gnt         <= '0;
            rom_enable  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          gnt <= '0;
          if (last_beat) begin
            state      <= ST_ARB;
            rom_enable <= 1'b1;
          end else begin
            rom_address <= rom_address + ADDR_W'(1);
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  // Return pipe: stage 1 lines up with ROM output, stage 2 is the client-facing register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      id_s1    <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], issuing};
      id_s1    <= cur_id;
      rd_valid <= vld_pipe[1] ? (N_REQ'(1) << id_s1) : '0;
      if (vld_pipe[1]) rd_data <= rom_data;
    end
  end
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter; ROM model holds mem[i] = i[7:0].
module tb_rom_read_arbiter;
  localparam int N_REQ  = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [N_REQ-1:0]             req;
  logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0][1:0]        req_len;
  logic [N_REQ-1:0]             gnt;
  logic [ADDR_W-1:0]            rom_address;
  logic                         rom_enable;
  logic [DATA_W-1:0]            rom_data = '0;
  logic [DATA_W-1:0]            rd_data;
  logic [N_REQ-1:0]             rd_valid;
  logic                         busy;

  typedef struct {
    int          id;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  rom_read_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .gnt         (gnt),
    .rom_address (rom_address),
    .rom_enable  (rom_enable),
    .rom_data    (rom_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: enable low reads, high forces zero.
  always @(posedge clk) rom_data <= rom_enable ? 8'h00 : rom_address[7:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    req_len = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Return monitor: every rd_valid beat must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rd_valid != '0) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected", 32'(rd_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("rd_valid", 32'(rd_valid), 32'(1) << e.id);
        chk("rd_data", 32'(rd_data), 32'(e.data));
      end
    end
  end

  initial begin
    int ord[5];
    int ord2[3];
    int g, n3, seen;
    bit saw3;

    req      = '0;
    req_addr = '0;
    req_len  = '0;

    // Reset values
    tick;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ren", 32'(rom_enable), 32'h1);
    chk("rst_addr", 32'(rom_address), 32'h0);
    chk("rst_rdata", 32'(rd_data), 32'h0);
    chk("rst_rvalid", 32'(rd_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Single read
    req_addr[2] = 10'h105;
    req = 4'b0100;
    push(2, 8'h05);
    tick;
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_addr", 32'(rom_address), 32'h105);
    chk("single_ren", 32'(rom_enable), 32'h0);
    chk("single_busy0", 32'(busy), 32'h1);
    req = '0;
    tick;
    chk("single_gnt_off", 32'(gnt), 32'h0);
    chk("single_ren_arb", 32'(rom_enable), 32'h1);
    chk("single_busy1", 32'(busy), 32'h1);
    tick;
    chk("single_busy2", 32'(busy), 32'h1);
    tick;
    chk("single_busy3", 32'(busy), 32'h0);
    chk("single_drain", 32'(sb.size()), 32'h0);

    // Contention: all four held, round-robin from requester 0
    do_reset;
    for (int i = 0; i < N_REQ; i++) req_addr[i] = ADDR_W'(32'h20 + i * 17);
    ord = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) push(ord[i], 8'(32'h20 + ord[i] * 17));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("cont_gnt", 32'(gnt), 32'(1) << ord[i]);
      if (i == 4) req = '0;
      tick;
      chk("cont_gap", 32'(gnt), 32'h0);
      chk("cont_ren", 32'(rom_enable), 32'h1);
    end
    repeat (4) tick;
    chk("cont_drain", 32'(sb.size()), 32'h0);

    // Burst across the address wrap
    do_reset;
    req_addr[1] = 10'h3FE;
    req_len[1]  = 2'd3;
    req = 4'b0010;
`ifdef ROM_ARB_BURST_EN
    push(1, 8'hFE);
    push(1, 8'hFF);
    push(1, 8'h00);
    push(1, 8'h01);
`else
    push(1, 8'hFE);
`endif
    tick;
    chk("burst_gnt", 32'(gnt), 32'h2);
    chk("burst_addr0", 32'(rom_address), 32'h3FE);
    req = '0;
    tick;
    chk("burst_gnt_off", 32'(gnt), 32'h0);
`ifdef ROM_ARB_BURST_EN
    chk("burst_addr1", 32'(rom_address), 32'h3FF);
    chk("burst_ren1", 32'(rom_enable), 32'h0);
    tick;
    chk("burst_addr2", 32'(rom_address), 32'h000);
`else
    chk("burst_ren1", 32'(rom_enable), 32'h1);
`endif
    repeat (8) tick;
    chk("burst_drain", 32'(sb.size()), 32'h0);
    chk("burst_busy", 32'(busy), 32'h0);

    // Reset during the second ISSUE cycle
    do_reset;
    req_addr[1] = 10'h3FE;
    req_len[1]  = 2'd3;
    req = 4'b0010;
    tick;
    req = '0;
    tick;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_ren", 32'(rom_enable), 32'h1);
    chk("mid_rst_addr", 32'(rom_address), 32'h0);
    chk("mid_rst_rvalid", 32'(rd_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_rdata", 32'(rd_data), 32'h0);
    tick;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (rd_valid != '0) seen++;
    end
    chk("mid_rst_no_rd", 32'(seen), 32'h0);

    // Fairness: req[0] held, req[3] pulsed until granted
    do_reset;
    req_addr[0] = 10'h040;
    req_addr[3] = 10'h0C3;
    ord2 = '{0, 3, 0};
    push(0, 8'h40);
    push(3, 8'hC3);
    push(0, 8'h40);
    req = 4'b0001;
    g = 0;
    n3 = 0;
    saw3 = 1'b0;
    for (int c = 0; c < 20 && g < 3; c++) begin
      tick;
      if (gnt != '0) begin
        chk("fair_gnt", 32'(gnt), 32'(1) << ord2[g]);
        if (req[3] && !saw3) n3++;
        if (gnt[3]) begin
          saw3 = 1'b1;
          req[3] = 1'b0;
        end
        g++;
        if (g == 3) req[0] = 1'b0;
      end
      if (c == 0) req[3] = 1'b1;
    end
    chk("fair_count", 32'(g), 32'h3);
    chk("fair_wait", 32'(saw3 && n3 <= 2), 32'h1);
    repeat (4) tick;
    chk("fair_drain", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
